// File: rtl/sbox_sub_pipe.sv
// sbox_sub_pipe: pipelined AES byte substitution (FIPS-197 S-box / inverse S-box).
//
// LANES bytes are substituted per beat. The table lookup is combinational in
// front of slot 0; slots 1..STAGES-1 only delay the beat. Each beat carries
// its own mode bit and a sideband tag. Valid/ready handshake on both sides,
// with a collapsing pipeline so bubbles never cost throughput.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is combinational from out_ready
//   in_inv              0 = forward S-box, 1 = inverse S-box (ignored if INV_EN=0)
//   in_tag              sideband tag, carried unchanged
//   in_bytes            lane i = bits [8i+7:8i]
//   out_valid/out_ready output handshake
//   out_inv, out_tag    mode and tag of the beat on out_bytes
//   out_bytes           substituted bytes, same lane order as the input
module sbox_sub_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [LANES*8-1:0] in_bytes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag,
    output logic [LANES*8-1:0] out_bytes
);

    localparam int W = LANES * 8;

    // Element 0 is the leftmost byte, so SBOX[x] reads like the FIPS-197 table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic             valid;
        logic             inv;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     bytes;
    } slot_t;

    slot_t        slot_q [STAGES];
    logic         adv    [STAGES+1];  // adv[k]: slot k may take a new beat this cycle
    logic [W-1:0] fwd_d;
    logic [W-1:0] inv_tbl_d;
    logic [W-1:0] sub_d;
    logic         inv_d;

    always_comb begin
        fwd_d = '0;
        for (int i = 0; i < LANES; i++) begin
            fwd_d[8*i +: 8] = SBOX[in_bytes[8*i +: 8]];
        end
    end

    generate
        if (INV_EN) begin : g_inv
            localparam logic [0:255][7:0] INV_SBOX = {
                128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
                128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
                128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
                128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
                128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
                128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
                128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
                128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
            };

            always_comb begin
                inv_tbl_d = '0;
                for (int i = 0; i < LANES; i++) begin
                    inv_tbl_d[8*i +: 8] = INV_SBOX[in_bytes[8*i +: 8]];
                end
            end

            assign inv_d = in_inv;
        end else begin : g_fwd_only
            // Forward-only build: mode bit is forced low so out_inv always reads 0.
            assign inv_tbl_d = '0;
            assign inv_d     = 1'b0;
        end
    endgenerate

    assign sub_d = inv_d ? inv_tbl_d : fwd_d;

    // Stall chain, evaluated from the output end backwards so each slot sees
    // whether the slot after it moves this cycle.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !slot_q[k].valid || adv[k+1];
        end
    end

    assign in_ready = adv[0] && !rst;

    // NOTE: payload fields are reset along with the valid bits because the
    // outputs must read zero after reset; only the valid bits matter for flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                slot_q[0].valid <= in_valid;
                // Payload is loaded only for real beats so idle input values
                // never disturb the registers.
                if (in_valid) begin
                    slot_q[0].inv   <= inv_d;
                    slot_q[0].tag   <= in_tag;
                    slot_q[0].bytes <= sub_d;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    slot_q[k].valid <= slot_q[k-1].valid;
                    if (slot_q[k-1].valid) begin
                        slot_q[k].inv   <= slot_q[k-1].inv;
                        slot_q[k].tag   <= slot_q[k-1].tag;
                        slot_q[k].bytes <= slot_q[k-1].bytes;
                    end
                end
            end
        end
    end

    assign out_valid = slot_q[STAGES-1].valid;
    assign out_inv   = slot_q[STAGES-1].inv;
    assign out_tag   = slot_q[STAGES-1].tag;
    assign out_bytes = slot_q[STAGES-1].bytes;

endmodule
